// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared 1-bit full adder walks the operands LSB first,
// with valid/ready handshakes on both the operand and the result side.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             input_clk,
    input  logic             input_reset,
    input  logic             input_valid,
    output logic             output_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_carry,
    output logic             output_valid,
    input  logic             input_ready,
    output logic [WIDTH-1:0] output_sum,
    output logic             output_carry,
    output logic             output_overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               fa_sum_s;
    logic               fa_cout_s;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (input_valid) begin
                    a_sh_d  = input_a;
                    b_sh_d  = input_b;
                    carry_d = input_carry;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts
                a_sh_d             = a_sh_q >> 1'b1;
                b_sh_d             = b_sh_q >> 1'b1;
                sum_d              = sum_q >> 1'b1;
                sum_d[WIDTH-1]     = fa_sum_s;
                carry_d            = fa_cout_s;
                cnt_d              = cnt_q + CNT_W'(1'b1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = fa_cout_s;
                    ovf_d   = carry_q ^ fa_cout_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (input_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge input_clk or posedge input_reset) begin
        if (input_reset) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign output_ready    = (state_q == ST_IDLE);
    assign output_valid    = (state_q == ST_DONE);
    assign output_sum      = sum_q;
    assign output_carry    = cout_q;
    assign output_overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): the driver pushes expected
// results at each accept, the monitor pops and compares when output_valid rises.

module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_carry = 1'b0;
    logic         in_ready = 1'b1;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .input_clk       (clk),
        .input_reset     (rst),
        .input_valid     (in_valid),
        .output_ready    (out_ready),
        .input_a         (in_a),
        .input_b         (in_b),
        .input_carry     (in_carry),
        .output_valid    (out_valid),
        .input_ready     (in_ready),
        .output_sum      (out_sum),
        .output_carry    (out_carry),
        .output_overflow (out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t        e;
        logic [W:0]  full;
        logic [W-1:0] low;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        low   = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin};
        e.sum = full[W-1:0];
        e.c   = full[W];
        e.o   = low[W-1] ^ full[W];
        e.acc = 0;
        return e;
    endfunction

    // Monitor: one scoreboard pop per rising output_valid
    bit   seen = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: actual sum=0x%0h required none", out_sum);
            end else begin
                me = exp_q.pop_front();
                chk("sum", int'(out_sum), int'(me.sum));
                chk("carry", int'(out_carry), int'(me.c));
                chk("overflow", int'(out_ovf), int'(me.o));
                chk("latency", cyc - me.acc, W);
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!out_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        in_a     = a;
        in_b     = b;
        in_carry = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e     = model(a, b, cin);
        e.acc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(out_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_carry", int'(out_carry), 0);
        chk("rst_ovf", int'(out_ovf), 0);
        rst = 1'b0;

        // Directed vectors
        issue(8'h12, 8'h34, 1'b0);
        issue(8'hFF, 8'h01, 1'b0);
        issue(8'hFF, 8'h00, 1'b1);
        issue(8'h7F, 8'h01, 1'b0);
        issue(8'h80, 8'h80, 1'b0);
        drain();

        // New operands with input_valid held during RUN are ignored
        @(negedge clk);
        while (!out_ready) @(negedge clk);
        in_a = 8'h7F; in_b = 8'h01; in_carry = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        e = model(8'h7F, 8'h01, 1'b0);
        e.acc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        in_a = 8'h55; in_b = 8'h22; in_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("run_ready_low", int'(out_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Stall in DONE: outputs must hold for 5 cycles, then hold after return to IDLE
        in_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_sum", int'(out_sum), 32'h46);
            chk("stall_carry", int'(out_carry), 0);
        end
        in_ready = 1'b1;
        @(negedge clk);
        chk("post_ack_ready", int'(out_ready), 1);
        chk("post_ack_valid", int'(out_valid), 0);
        chk("post_ack_sum_held", int'(out_sum), 32'h46);

        // Reset asserted after three RUN bits aborts the operation
        issue(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", int'(out_ready), 1);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_sum", int'(out_sum), 0);
        chk("abort_carry", int'(out_carry), 0);
        chk("abort_ovf", int'(out_ovf), 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        issue(8'hFF, 8'h01, 1'b0);
        drain();

        // Back-to-back: new operands presented during DONE, accepted right after the ack
        issue(8'h80, 8'h80, 1'b0);
        wait_valid();
        in_a = 8'h7F; in_b = 8'h01; in_carry = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_idle_ready", int'(out_ready), 1);
        @(posedge clk);
        #1;
        e = model(8'h7F, 8'h01, 1'b1);
        e.acc = cyc;
        exp_q.push_back(e);
        chk("b2b_accepted", int'(out_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Random operations against the A+B+cin model
        for (int i = 0; i < 300; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
